// File: rtl/rng_word_packer.sv
// Requests bytes from the TRNG sample unit, packs NBYTE of them little-endian into words and
// buffers the words in a DEPTH-entry first-word-fall-through FIFO. Optional feature: RNG_HEALTH_EN.
module rng_word_packer #(
  parameter int NBYTE     = 4,
  parameter int DEPTH     = 8,
  parameter int REP_LIMIT = 8
) (
  input  logic                   CLK,
  input  logic                   RST_X,
  input  logic                   ENABLE,
  input  logic                   FLUSH,
  output logic                   RNG_EN,
  input  logic [7:0]             RNG_DATA,
  input  logic                   RNG_VALID,
  output logic [31:0]            WORD_OUT,
  output logic                   WORD_VALID,
  input  logic                   WORD_READY,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   HEALTH_ERR,
  output logic [1:0]             dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  if (NBYTE < 1 || NBYTE > 4 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || REP_LIMIT < 1)
  begin : g_bad_params
    $error("rng_word_packer: illegal parameter set");
  end

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [1:0]    idx;
  logic [31:0]   partial;
  logic [31:0]   lane;
  logic [31:0]   assembled;
  logic          capture;
  logic          last_byte_of_word;
  logic          push;
  logic          pop;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   mem [DEPTH];

  assign dbg_state = state;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (ENABLE && LEVEL < LW'(DEPTH) && !HEALTH_ERR && !FLUSH) state_next = S_REQ;
      S_REQ:  state_next = S_WAIT;
      S_WAIT: if (RNG_VALID) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // RNG_EN comes straight from a flop so the TRNG unit never sees a combinational path.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state  <= S_IDLE;
      RNG_EN <= 1'b0;
    end else begin
      state  <= state_next;
      RNG_EN <= (state_next == S_REQ);
    end
  end

  // A byte arriving in the same cycle as FLUSH is dropped; the FSM still leaves WAIT.
  assign capture           = (state == S_WAIT) && RNG_VALID && !FLUSH;
  assign last_byte_of_word = (idx == 2'(NBYTE - 1));
  assign lane              = 32'(RNG_DATA) << {idx, 3'b000};
  assign assembled         = partial | lane;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      idx     <= '0;
      partial <= '0;
    end else if (FLUSH) begin
      idx     <= '0;
      partial <= '0;
    end else if (capture) begin
      if (last_byte_of_word) begin
        idx     <= '0;
        partial <= '0;
      end else begin
        idx     <= idx + 2'd1;
        partial <= assembled;
      end
    end
  end

  // Handshake: a word moves on every edge where WORD_VALID & WORD_READY are both high;
  // WORD_VALID and WORD_OUT never depend on WORD_READY and hold until the word is taken.
  assign WORD_VALID = (LEVEL != '0);
  assign WORD_OUT   = WORD_VALID ? mem[rd_ptr] : 32'h0;
  assign push       = capture && last_byte_of_word && (LEVEL < LW'(DEPTH) || pop);
  assign pop        = WORD_VALID && WORD_READY && !FLUSH;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= assembled;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      LEVEL  <= '0;
    end else if (FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      LEVEL  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   LEVEL <= LEVEL + LW'(1);
        2'b01:   LEVEL <= LEVEL - LW'(1);
        default: LEVEL <= LEVEL;
      endcase
    end
  end

`ifdef RNG_HEALTH_EN
  localparam int RW = $clog2(REP_LIMIT + 1);

  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_next;
  logic [7:0]    last_byte;

  // Run length including the byte being captured; saturates at the trip level.
  always_comb begin
    rep_next = RW'(1);
    if (rep_cnt != '0 && RNG_DATA == last_byte)
      rep_next = (rep_cnt == RW'(REP_LIMIT)) ? rep_cnt : rep_cnt + RW'(1);
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      rep_cnt    <= '0;
      last_byte  <= '0;
      HEALTH_ERR <= 1'b0;
    end else if (FLUSH) begin
      rep_cnt    <= '0;
      last_byte  <= '0;
      HEALTH_ERR <= 1'b0;
    end else if (capture) begin
      rep_cnt   <= rep_next;
      last_byte <= RNG_DATA;
      if (rep_next == RW'(REP_LIMIT)) HEALTH_ERR <= 1'b1;
    end
  end
`else
  assign HEALTH_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_rng_word_packer.sv
// Bench for rng_word_packer: stub TRNG answering 3 cycles after each request, byte-level
// packing model feeding an expected-word queue, one task per scenario.
module tb_rng_word_packer;
  localparam int NBYTE = 4;
  localparam int DEPTH = 8;
  localparam int REP_LIMIT = 8;

  logic        CLK = 1'b0;
  logic        RST_X;
  logic        ENABLE;
  logic        FLUSH;
  logic        RNG_EN;
  logic [7:0]  RNG_DATA;
  logic        RNG_VALID;
  logic [31:0] WORD_OUT;
  logic        WORD_VALID;
  logic        WORD_READY;
  logic [3:0]  LEVEL;
  logic        HEALTH_ERR;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  byte_q[$];
  int          bytes_given = 0;
  logic [1:0]  mdl_idx = '0;
  logic [31:0] mdl_part = '0;
  bit          stray_req = 1'b0;
  int          en_pulses = 0;
  int          en_long = 0;
  bit          en_prev = 1'b0;

  rng_word_packer #(.NBYTE(NBYTE), .DEPTH(DEPTH), .REP_LIMIT(REP_LIMIT)) dut (
    .CLK(CLK), .RST_X(RST_X), .ENABLE(ENABLE), .FLUSH(FLUSH), .RNG_EN(RNG_EN),
    .RNG_DATA(RNG_DATA), .RNG_VALID(RNG_VALID), .WORD_OUT(WORD_OUT),
    .WORD_VALID(WORD_VALID), .WORD_READY(WORD_READY), .LEVEL(LEVEL),
    .HEALTH_ERR(HEALTH_ERR), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // stub TRNG plus packing model: a byte counts only if RST_X and ~FLUSH at its edge
  initial begin
    RNG_VALID = 1'b0;
    RNG_DATA  = '0;
    forever begin
      @(posedge CLK); #1;
      if (RNG_EN === 1'b1) begin
        repeat (3) @(posedge CLK);
        #1;
        RNG_DATA  = (byte_q.size() > 0) ? byte_q.pop_front() : 8'($urandom_range(0, 255));
        RNG_VALID = 1'b1;
        bytes_given++;
        @(posedge CLK);
        if (RST_X === 1'b1 && FLUSH === 1'b0) begin
          mdl_part = mdl_part | (32'(RNG_DATA) << (8 * mdl_idx));
          if (mdl_idx == 2'(NBYTE - 1)) begin
            exp_q.push_back(mdl_part);
            mdl_part = '0;
            mdl_idx  = '0;
          end else begin
            mdl_idx = mdl_idx + 2'd1;
          end
        end
        #1 RNG_VALID = 1'b0;
      end else if (stray_req) begin
        RNG_DATA  = 8'h5A;
        RNG_VALID = 1'b1;
        @(posedge CLK);
        #1 RNG_VALID = 1'b0;
        stray_req = 1'b0;
      end
    end
  end

  // request pulse monitor
  initial begin
    forever begin
      @(posedge CLK); #1;
      if (RNG_EN === 1'b1 && !en_prev) en_pulses++;
      if (RNG_EN === 1'b1 && en_prev) en_long++;
      en_prev = (RNG_EN === 1'b1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    exp_q.delete();
    mdl_idx  = '0;
    mdl_part = '0;
  endtask

  // driver: keeps ENABLE high until n more bytes have been handed to the DUT
  task automatic run_bytes(input int n, input bit keep);
    int target;
    int cyc;
    target = bytes_given + n;
    cyc = 0;
    ENABLE = 1'b1;
    while (bytes_given < target && cyc < 20 * n + 20) begin
      @(posedge CLK); #2;
      cyc++;
    end
    if (!keep) ENABLE = 1'b0;
    total++;
    if (bytes_given < target) begin
      bad++;
      $display("FAIL run_bytes_timeout: given=%0d required=%0d", bytes_given, target);
    end
  endtask

  task automatic do_flush();
    @(negedge CLK);
    FLUSH = 1'b1;
    @(posedge CLK);
    model_clear();
    #1 FLUSH = 1'b0;
  endtask

  task automatic test_reset();
    RST_X = 1'b0; ENABLE = 1'b0; FLUSH = 1'b0; WORD_READY = 1'b0;
    repeat (2) @(negedge CLK);
    total++;
    if ({RNG_EN, WORD_VALID, HEALTH_ERR, LEVEL, WORD_OUT, dbg_state} !== '0) begin
      bad++; $display("FAIL reset_outputs: en=%b v=%b h=%b lvl=%0d w=%h st=%0d required all 0",
                      RNG_EN, WORD_VALID, HEALTH_ERR, LEVEL, WORD_OUT, dbg_state);
    end
    RST_X = 1'b1;
    model_clear();
    run_bytes(5, 1'b1);
    total++;
    if (LEVEL !== 4'd1) begin bad++; $display("FAIL reset_pre_level: got %0d required 1", LEVEL); end
    #1 RST_X = 1'b0;
    model_clear();
    #1;
    total++;
    if ({RNG_EN, WORD_VALID, HEALTH_ERR, LEVEL, WORD_OUT} !== '0) begin
      bad++; $display("FAIL reset_midrun: en=%b v=%b h=%b lvl=%0d w=%h required all 0",
                      RNG_EN, WORD_VALID, HEALTH_ERR, LEVEL, WORD_OUT);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      total++;
      if (RNG_EN !== 1'b0) begin bad++; $display("FAIL reset_no_req: got %b required 0", RNG_EN); end
    end
    ENABLE = 1'b0;
    RST_X = 1'b1;
    repeat (2) @(negedge CLK);
    total++;
    if (LEVEL !== 4'd0) begin bad++; $display("FAIL reset_release_level: got %0d required 0", LEVEL); end
  endtask

  task automatic test_single_word();
    int p0;
    int l0;
    p0 = en_pulses; l0 = en_long;
    byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_bytes(4, 1'b0);
    repeat (3) @(negedge CLK);
    total++;
    if (WORD_OUT !== 32'h44332211 || WORD_VALID !== 1'b1 || LEVEL !== 4'd1) begin
      bad++; $display("FAIL single_word: got w=%h v=%b lvl=%0d required 44332211 1 1", WORD_OUT, WORD_VALID, LEVEL);
    end
    total++;
    if (en_pulses - p0 != 4 || en_long != l0) begin
      bad++; $display("FAIL single_pulses: pulses=%0d long=%0d required 4 0", en_pulses - p0, en_long - l0);
    end
    WORD_READY = 1'b1;
    total++;
    if (WORD_OUT !== exp_q[0]) begin bad++; $display("FAIL single_pop: got %h required %h", WORD_OUT, exp_q[0]); end
    void'(exp_q.pop_front());
    @(negedge CLK);
    WORD_READY = 1'b0;
    total++;
    if (LEVEL !== 4'd0 || WORD_VALID !== 1'b0 || WORD_OUT !== 32'h0) begin
      bad++; $display("FAIL single_empty: lvl=%0d v=%b w=%h required 0 0 0", LEVEL, WORD_VALID, WORD_OUT);
    end
  endtask

  task automatic test_full();
    int p0;
    WORD_READY = 1'b0;
    for (int i = 0; i < 32; i++) byte_q.push_back(8'(i * 7 + 3));
    run_bytes(32, 1'b1);
    @(negedge CLK);
    p0 = en_pulses;
    repeat (10) @(negedge CLK);
    total++;
    if (LEVEL !== 4'd8 || en_pulses != p0) begin
      bad++; $display("FAIL full_stall: lvl=%0d new_pulses=%0d required 8 0", LEVEL, en_pulses - p0);
    end
    total++;
    if (WORD_OUT !== exp_q[0]) begin bad++; $display("FAIL full_head: got %h required %h", WORD_OUT, exp_q[0]); end
    void'(exp_q.pop_front());
    p0 = en_pulses;
    WORD_READY = 1'b1;
    @(negedge CLK);
    WORD_READY = 1'b0;
    total++;
    if (LEVEL !== 4'd7) begin bad++; $display("FAIL full_pop_level: got %0d required 7", LEVEL); end
    @(negedge CLK);
    ENABLE = 1'b0;
    total++;
    if (en_pulses != p0 + 1) begin bad++; $display("FAIL full_resume: pulses=%0d required 1", en_pulses - p0); end
    repeat (8) @(negedge CLK);
    run_bytes(3, 1'b0);
    repeat (3) @(negedge CLK);
    total++;
    if (LEVEL !== 4'd8) begin bad++; $display("FAIL full_refill: got %0d required 8", LEVEL); end
    WORD_READY = 1'b1;
    while (exp_q.size() > 0) begin
      total++;
      if (WORD_VALID !== 1'b1 || WORD_OUT !== exp_q[0]) begin
        bad++; $display("FAIL full_drain: got v=%b %h required %h", WORD_VALID, WORD_OUT, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge CLK);
    end
    WORD_READY = 1'b0;
    total++;
    if (LEVEL !== 4'd0) begin bad++; $display("FAIL full_drained: got %0d required 0", LEVEL); end
  endtask

  task automatic test_push_pop();
    WORD_READY = 1'b0;
    run_bytes(12, 1'b0);
    repeat (3) @(negedge CLK);
    total++;
    if (LEVEL !== 4'd3) begin bad++; $display("FAIL pp_pre_level: got %0d required 3", LEVEL); end
    run_bytes(4, 1'b0);
    total++;
    if (WORD_OUT !== exp_q[0]) begin bad++; $display("FAIL pp_head: got %h required %h", WORD_OUT, exp_q[0]); end
    void'(exp_q.pop_front());
    WORD_READY = 1'b1;
    @(posedge CLK);
    #1 WORD_READY = 1'b0;
    @(negedge CLK);
    total++;
    if (LEVEL !== 4'd3) begin bad++; $display("FAIL pp_level: got %0d required 3", LEVEL); end
    WORD_READY = 1'b1;
    while (exp_q.size() > 0) begin
      total++;
      if (WORD_VALID !== 1'b1 || WORD_OUT !== exp_q[0]) begin
        bad++; $display("FAIL pp_order: got v=%b %h required %h", WORD_VALID, WORD_OUT, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge CLK);
    end
    WORD_READY = 1'b0;
    total++;
    if (LEVEL !== 4'd0) begin bad++; $display("FAIL pp_drained: got %0d required 0", LEVEL); end
  endtask

  task automatic test_flush();
    int cyc;
    int p0;
    WORD_READY = 1'b0;
    run_bytes(4, 1'b0);
    run_bytes(2, 1'b0);
    repeat (3) @(negedge CLK);
    total++;
    if (LEVEL !== 4'd1) begin bad++; $display("FAIL flush_pre_level: got %0d required 1", LEVEL); end
    do_flush();
    @(negedge CLK);
    total++;
    if (LEVEL !== 4'd0 || WORD_VALID !== 1'b0 || WORD_OUT !== 32'h0) begin
      bad++; $display("FAIL flush_clear: lvl=%0d v=%b w=%h required 0 0 0", LEVEL, WORD_VALID, WORD_OUT);
    end
    // flush coincident with a returned byte: that byte must vanish
    run_bytes(1, 1'b0);
    FLUSH = 1'b1;
    @(posedge CLK);
    model_clear();
    #1 FLUSH = 1'b0;
    repeat (3) @(negedge CLK);
    // flush while a request is outstanding: its byte becomes byte 0 of the next word
    byte_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    p0 = en_pulses;
    cyc = 0;
    ENABLE = 1'b1;
    while (en_pulses == p0 && cyc < 10) begin @(posedge CLK); #2; cyc++; end
    ENABLE = 1'b0;
    total++;
    if (en_pulses == p0) begin bad++; $display("FAIL flush_req_timeout: pulses=%0d required 1", en_pulses - p0); end
    do_flush();
    run_bytes(4, 1'b0);
    repeat (3) @(negedge CLK);
    total++;
    if (WORD_OUT !== 32'hDDCCBBAA || LEVEL !== 4'd1) begin
      bad++; $display("FAIL flush_next_word: got %h lvl=%0d required ddccbbaa 1", WORD_OUT, LEVEL);
    end
    WORD_READY = 1'b1;
    total++;
    if (WORD_OUT !== exp_q[0]) begin bad++; $display("FAIL flush_model: got %h required %h", WORD_OUT, exp_q[0]); end
    void'(exp_q.pop_front());
    @(negedge CLK);
    WORD_READY = 1'b0;
  endtask

  task automatic test_stray();
    int cyc;
    WORD_READY = 1'b0;
    run_bytes(4, 1'b0);
    run_bytes(2, 1'b0);
    repeat (4) @(negedge CLK);
    stray_req = 1'b1;
    cyc = 0;
    while (stray_req && cyc < 10) begin @(negedge CLK); cyc++; end
    repeat (3) @(negedge CLK);
    total++;
    if (LEVEL !== 4'd1 || WORD_OUT !== exp_q[0] || dbg_state !== 2'd0) begin
      bad++; $display("FAIL stray_ignored: lvl=%0d w=%h st=%0d required 1 %h 0", LEVEL, WORD_OUT, dbg_state, exp_q[0]);
    end
    run_bytes(2, 1'b0);
    repeat (3) @(negedge CLK);
    total++;
    if (LEVEL !== 4'd2) begin bad++; $display("FAIL stray_level: got %0d required 2", LEVEL); end
    WORD_READY = 1'b1;
    while (exp_q.size() > 0) begin
      total++;
      if (WORD_VALID !== 1'b1 || WORD_OUT !== exp_q[0]) begin
        bad++; $display("FAIL stray_words: got v=%b %h required %h", WORD_VALID, WORD_OUT, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge CLK);
    end
    WORD_READY = 1'b0;
  endtask

  task automatic test_health();
    int p0;
    int cyc;
    WORD_READY = 1'b0;
    do_flush();
    repeat (8) byte_q.push_back(8'hA5);
`ifdef RNG_HEALTH_EN
    run_bytes(8, 1'b1);
    @(negedge CLK);
    total++;
    if (HEALTH_ERR !== 1'b0) begin bad++; $display("FAIL health_early: got %b required 0", HEALTH_ERR); end
    @(negedge CLK);
    total++;
    if (HEALTH_ERR !== 1'b1) begin bad++; $display("FAIL health_set: got %b required 1", HEALTH_ERR); end
    p0 = en_pulses;
    repeat (10) @(negedge CLK);
    total++;
    if (en_pulses != p0 || LEVEL !== 4'd2) begin
      bad++; $display("FAIL health_block: new_pulses=%0d lvl=%0d required 0 2", en_pulses - p0, LEVEL);
    end
    WORD_READY = 1'b1;
    while (exp_q.size() > 0) begin
      total++;
      if (WORD_VALID !== 1'b1 || WORD_OUT !== exp_q[0]) begin
        bad++; $display("FAIL health_pop: got v=%b %h required %h", WORD_VALID, WORD_OUT, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge CLK);
    end
    WORD_READY = 1'b0;
    do_flush();
    @(negedge CLK);
    total++;
    if (HEALTH_ERR !== 1'b0) begin bad++; $display("FAIL health_flush: got %b required 0", HEALTH_ERR); end
    cyc = 0;
    while (en_pulses == p0 && cyc < 4) begin @(negedge CLK); cyc++; end
    ENABLE = 1'b0;
    total++;
    if (en_pulses == p0) begin bad++; $display("FAIL health_resume: pulses=%0d required >0", en_pulses - p0); end
    repeat (8) @(negedge CLK);
`else
    run_bytes(8, 1'b0);
    repeat (3) @(negedge CLK);
    total++;
    if (HEALTH_ERR !== 1'b0 || LEVEL !== 4'd2) begin
      bad++; $display("FAIL health_off: h=%b lvl=%0d required 0 2", HEALTH_ERR, LEVEL);
    end
    run_bytes(1, 1'b0);
    repeat (6) @(negedge CLK);
    total++;
    if (HEALTH_ERR !== 1'b0) begin bad++; $display("FAIL health_off_after: got %b required 0", HEALTH_ERR); end
    WORD_READY = 1'b1;
    while (exp_q.size() > 0) begin
      total++;
      if (WORD_VALID !== 1'b1 || WORD_OUT !== exp_q[0]) begin
        bad++; $display("FAIL health_off_pop: got v=%b %h required %h", WORD_VALID, WORD_OUT, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge CLK);
    end
    WORD_READY = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full();
    test_push_pop();
    test_flush();
    test_stray();
    test_health();
    repeat (4) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
